cmd_serializer: RTL and testbench

Read-side consumer of the 40→160 MHz command word FIFO. It pulls 16-bit command words using the FIFO's rd_cmd/cmd_valid handshake and serializes them MSB-first at one bit per clk160 cycle. Continuous 16-bit framing is kept at all times: IDLE words fill gaps when the FIFO has nothing, and SYNC words are inserted at a fixed frame interval. Output drives the emulated chip's serial command line.

---
 rtl/cmd_pkg.sv | 18 +
 rtl/cmd_piso16.sv | 37 +++
 rtl/cmd_serializer.sv | 103 ++++++++++
 tb/tb_cmd_serializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared command-path constants: word width and default SYNC/IDLE patterns.
// Also used by the LFSR generator side, so keep it free of serializer-only detail.
package cmd_pkg;

  localparam int CMD_W = 16;

  localparam logic [CMD_W-1:0] SYNC_WORD_DEF = 16'h817E;
  localparam logic [CMD_W-1:0] IDLE_WORD_DEF = 16'hAAAA;

  // Source of the word loaded at a frame boundary, in priority order.
  typedef enum logic [1:0] {
    SEL_SYNC   = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BYPASS = 2'd2,
    SEL_IDLE   = 2'd3
  } word_sel_e;

endpackage

// File: rtl/cmd_piso16.sv
// 16-bit parallel-load shift register, MSB first; loads on the boundary cycle
// (bit_cnt==15) and flags bit 0 of each frame with frame_start.
module cmd_piso16
  import cmd_pkg::*;
(
  input  logic             clk160,
  input  logic             rst,
  input  logic [CMD_W-1:0] load_word,
  output logic             boundary,
  output logic [3:0]       bit_cnt,
  output logic             ser_out,
  output logic             frame_start
);

  logic [CMD_W-1:0] shift_reg;

  assign boundary = (bit_cnt == 4'd15);
  assign ser_out  = shift_reg[CMD_W-1];

  // Reset parks bit_cnt at 15 so the first edge after release is a boundary.
  always_ff @(posedge clk160) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt     <= 4'd15;
      frame_start <= 1'b0;
    end else if (boundary) begin
      shift_reg   <= load_word;
      bit_cnt     <= 4'd0;
      frame_start <= 1'b1;
    end else begin
      shift_reg   <= {shift_reg[CMD_W-2:0], 1'b0};
      bit_cnt     <= bit_cnt + 4'd1;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_serializer.sv
// FIFO read-side command serializer: prefetches one word per frame, keeps
// continuous 16-bit framing with IDLE fill and periodic SYNC frames.
module cmd_serializer
  import cmd_pkg::*;
#(
  parameter logic [CMD_W-1:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter logic [CMD_W-1:0] IDLE_WORD     = IDLE_WORD_DEF,
  parameter int               SYNC_INTERVAL = 32,
  parameter int               PREFETCH_BIT  = 11
) (
  input  logic             clk160,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             rd_cmd,
  output logic             ser_out,
  output logic             frame_start,
  output logic [31:0]      cmd_count,
  output logic             proto_err
);

  localparam int             FW   = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
  localparam logic [FW-1:0]  LAST = FW'(SYNC_INTERVAL - 1);

  logic             boundary;
  logic [3:0]       bit_cnt;
  logic [FW-1:0]    frame_cnt;
  logic [CMD_W-1:0] hold_reg;
  logic             hold_valid;
  logic             rd_pending;
  logic             last_frame;
  logic             accept;
  word_sel_e        sel;
  logic [CMD_W-1:0] load_word;

  // The frame after the last one in the interval is always a sync frame.
  assign last_frame = (frame_cnt == LAST);
  assign accept     = cmd_valid & rd_pending & ~hold_valid;

  // No read ahead of a sync frame: the word would have nowhere to go.
  assign rd_cmd = ~rst & (bit_cnt == 4'(PREFETCH_BIT)) & ~hold_valid
                & ~rd_pending & ~last_frame;

  always_comb begin
    sel = SEL_IDLE;
    if (last_frame)      sel = SEL_SYNC;
    else if (hold_valid) sel = SEL_HOLD;
    else if (accept)     sel = SEL_BYPASS;
  end

  always_comb begin
    load_word = IDLE_WORD;
    case (sel)
      SEL_SYNC:   load_word = SYNC_WORD;
      SEL_HOLD:   load_word = hold_reg;
      SEL_BYPASS: load_word = cmd_data;
      default:    load_word = IDLE_WORD;
    endcase
  end

  always_ff @(posedge clk160) begin
    if (rst) begin
      frame_cnt  <= LAST;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      rd_pending <= 1'b0;
      cmd_count  <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (cmd_valid && !accept) proto_err <= 1'b1;
      if (boundary) begin
        frame_cnt  <= last_frame ? '0 : frame_cnt + 1'b1;
        // Any read still outstanding here is stale; a late word becomes an error.
        rd_pending <= 1'b0;
        if (sel == SEL_HOLD || sel == SEL_BYPASS) cmd_count <= cmd_count + 32'd1;
        if (sel == SEL_HOLD) begin
          hold_valid <= 1'b0;
        end else if (accept && sel == SEL_SYNC) begin
          hold_reg   <= cmd_data;
          hold_valid <= 1'b1;
        end
      end else begin
        if (rd_cmd) rd_pending <= 1'b1;
        if (accept) begin
          hold_reg   <= cmd_data;
          hold_valid <= 1'b1;
          rd_pending <= 1'b0;
        end
      end
    end
  end

  cmd_piso16 u_piso (
    .clk160      (clk160),
    .rst         (rst),
    .load_word   (load_word),
    .boundary    (boundary),
    .bit_cnt     (bit_cnt),
    .ser_out     (ser_out),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_cmd_serializer.sv
// Directed bench: two serializer instances (SYNC_INTERVAL=4/PREFETCH 11 and
// SYNC_INTERVAL=32/PREFETCH 4) fed by a small latency-programmable FIFO model.
module tb_cmd_serializer;

  logic clk160 = 1'b0;
  always #3 clk160 = ~clk160;

  logic        rst [2];
  logic        cmd_valid [2];
  logic [15:0] cmd_data [2];
  logic        rd_cmd [2];
  logic        ser_out [2];
  logic        frame_start [2];
  logic [31:0] cmd_count [2];
  logic        proto_err [2];

  int passed = 0;
  int total  = 0;

  cmd_serializer #(.SYNC_INTERVAL(4), .PREFETCH_BIT(11)) u4 (
    .clk160(clk160), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_data(cmd_data[0]),
    .rd_cmd(rd_cmd[0]), .ser_out(ser_out[0]), .frame_start(frame_start[0]),
    .cmd_count(cmd_count[0]), .proto_err(proto_err[0]));

  cmd_serializer #(.SYNC_INTERVAL(32), .PREFETCH_BIT(4)) u32 (
    .clk160(clk160), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_data(cmd_data[1]),
    .rd_cmd(rd_cmd[1]), .ser_out(ser_out[1]), .frame_start(frame_start[1]),
    .cmd_count(cmd_count[1]), .proto_err(proto_err[1]));

  // FIFO model: one read in flight, cmd_valid 'lat' cycles after rd_cmd.
  logic [15:0] mem [2][32];
  int          wp [2];
  int          rp [2];
  int          lat [2];
  int          cd [2];
  logic [15:0] fly [2];
  bit          inj [2];
  logic [15:0] inj_data [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_data[i] = 16'h0;
      wp[i] = 0; rp[i] = 0; lat[i] = 1; cd[i] = 0; fly[i] = 16'h0;
      inj[i] = 1'b0; inj_data[i] = 16'h0;
    end
  end

  always @(negedge clk160) begin
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      if (cd[i] > 0) begin
        cd[i] = cd[i] - 1;
        if (cd[i] == 0) begin cmd_valid[i] = 1'b1; cmd_data[i] = fly[i]; end
      end
      if (inj[i]) begin cmd_valid[i] = 1'b1; cmd_data[i] = inj_data[i]; inj[i] = 1'b0; end
      if (rd_cmd[i] === 1'b1 && wp[i] != rp[i]) begin
        fly[i] = mem[i][rp[i] % 32]; rp[i] = rp[i] + 1; cd[i] = lat[i];
      end
    end
  end

  task automatic push(input int i, input logic [15:0] w);
    mem[i][wp[i] % 32] = w;
    wp[i] = wp[i] + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Collects one frame starting at the next frame_start; rm[b]=1 if rd_cmd was high at bit b.
  task automatic get_frame(input int i, output logic [15:0] w, output logic [15:0] rm);
    int n = 0;
    bit extra_fs = 1'b0;
    @(negedge clk160);
    while (frame_start[i] !== 1'b1 && n < 40) begin @(negedge clk160); n++; end
    if (n >= 40) begin
      total++;
      $display("FAIL frame_timeout: inst %0d got no frame_start within 40 cycles", i);
    end
    w = 16'h0; rm = 16'h0;
    for (int b = 0; b < 16; b++) begin
      if (b > 0) @(negedge clk160);
      w     = {w[14:0], ser_out[i]};
      rm[b] = rd_cmd[i];
      if (b > 0 && frame_start[i] !== 1'b0) extra_fs = 1'b1;
    end
    chk("frame_start_only_bit0", {31'd0, extra_fs}, 32'd0);
  endtask

  task automatic chk_frame(input int i, input string name, input logic [15:0] ew, input logic [15:0] erm);
    logic [15:0] w, rm;
    get_frame(i, w, rm);
    chk({name, "_word"}, {16'd0, w}, {16'd0, ew});
    chk({name, "_rdmask"}, {16'd0, rm}, {16'd0, erm});
  endtask

  task automatic chk_reset_outs(input int i, input string name);
    chk({name, "_ser"},  {31'd0, ser_out[i]},     32'd0);
    chk({name, "_fs"},   {31'd0, frame_start[i]}, 32'd0);
    chk({name, "_rd"},   {31'd0, rd_cmd[i]},      32'd0);
    chk({name, "_cnt"},  cmd_count[i],            32'd0);
    chk({name, "_perr"}, {31'd0, proto_err[i]},   32'd0);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [15:0] rmask;
  } fexp_t;

  fexp_t idle_tab [5];
  fexp_t strm_tab [10];

  initial begin
    idle_tab[0] = '{16'h817E, 16'h0800};
    idle_tab[1] = '{16'hAAAA, 16'h0800};
    idle_tab[2] = '{16'hAAAA, 16'h0800};
    idle_tab[3] = '{16'hAAAA, 16'h0000};  // frame before sync: no prefetch
    idle_tab[4] = '{16'h817E, 16'h0800};
    strm_tab[0] = '{16'h817E, 16'h0010};
    for (int k = 1; k <= 8; k++) strm_tab[k] = '{16'(k), 16'h0010};
    strm_tab[9] = '{16'hAAAA, 16'h0010};

    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(negedge clk160);
    chk_reset_outs(0, "u4_reset");
    chk_reset_outs(1, "u32_reset");

    // Empty FIFO, SYNC_INTERVAL=4
    rst[0] = 1'b0;
    for (int f = 0; f < 5; f++) chk_frame(0, $sformatf("idle_f%0d", f), idle_tab[f].word, idle_tab[f].rmask);

    // Single word, latency 1: fetched at bit 11 of frame 1, sent in frame 2
    push(0, 16'h1234);
    chk_frame(0, "single_f1", 16'hAAAA, 16'h0800);
    chk_frame(0, "single_f2", 16'h1234, 16'h0800);
    chk("single_cnt",  cmd_count[0], 32'd1);
    chk("single_perr", {31'd0, proto_err[0]}, 32'd0);

    // Latency 4: word arrives on the boundary cycle and takes the bypass path
    lat[0] = 4;
    push(0, 16'h5A5A);
    chk_frame(0, "bypass_f3", 16'hAAAA, 16'h0000);
    chk_frame(0, "bypass_f0", 16'h817E, 16'h0800);
    chk_frame(0, "bypass_f1", 16'h5A5A, 16'h0800);
    chk("bypass_cnt",  cmd_count[0], 32'd2);
    chk_frame(0, "bypass_f2", 16'hAAAA, 16'h0800);
    chk("bypass_perr", {31'd0, proto_err[0]}, 32'd0);

    // Unsolicited word at bit 0 of frame 3: dropped, sticky error
    @(posedge clk160); #1;
    inj_data[0] = 16'hBEEF; inj[0] = 1'b1;
    chk_frame(0, "unsol_f3", 16'hAAAA, 16'h0000);
    chk("unsol_perr", {31'd0, proto_err[0]}, 32'd1);
    chk_frame(0, "unsol_f0", 16'h817E, 16'h0800);
    chk_frame(0, "unsol_f1", 16'hAAAA, 16'h0800);
    chk("unsol_cnt",        cmd_count[0], 32'd2);
    chk("unsol_perr_stuck", {31'd0, proto_err[0]}, 32'd1);

    // Streaming 1..8, SYNC_INTERVAL=32
    for (int k = 1; k <= 8; k++) push(1, 16'(k));
    rst[1] = 1'b0;
    for (int f = 0; f < 10; f++) chk_frame(1, $sformatf("strm_f%0d", f), strm_tab[f].word, strm_tab[f].rmask);
    chk("strm_cnt",  cmd_count[1], 32'd8);
    chk("strm_perr", {31'd0, proto_err[1]}, 32'd0);

    // Reset at bit 7 of frame 10 while C0DE sits in the hold register
    push(1, 16'hC0DE);
    repeat (8) @(negedge clk160);
    rst[1] = 1'b1;
    @(negedge clk160);
    chk_reset_outs(1, "midrst");
    repeat (2) @(negedge clk160);
    rst[1] = 1'b0;
    chk_frame(1, "midrst_f0", 16'h817E, 16'h0010);
    chk_frame(1, "midrst_f1", 16'hAAAA, 16'h0010);
    chk("midrst_cnt", cmd_count[1], 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
